// File: rtl/spi_arb_pkg.sv
// Shared types and sizes for the two-requester SPI flash arbiter.
package spi_arb_pkg;

    localparam int NUM_REQ = 2;
    localparam int BYTE_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        WAIT_BYTE,
        SHIFT,
        CS_HOLD,
        CS_IDLE
    } state_t;

    // Lone requester wins outright; on a tie the one that did not go last wins.
    function automatic logic pick_winner(input logic [NUM_REQ-1:0] req, input logic rr_last);
        if (req[0] && req[1]) return ~rr_last;
        return req[1];
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// One SPI mode-0 byte, MSB first: divider, bit counter, sck/mosi drive and miso capture.
module spi_byte_shifter
    import spi_arb_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] tx_byte,
    output logic              done,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              spi_sck,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [7:0]        div_cnt;
    logic [2:0]        bit_cnt;
    logic              active;
    logic [BYTE_W-1:0] tx_sh;
    logic [BYTE_W-1:0] rx_sh;

    // mosi is the top of the transmit shifter, which only moves on falling edges.
    assign spi_mosi = tx_sh[BYTE_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            active  <= 1'b0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            rx_byte <= '0;
            spi_sck <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                active  <= 1'b1;
                spi_sck <= 1'b0;
                div_cnt <= '0;
                bit_cnt <= '0;
                tx_sh   <= tx_byte;
            end else if (active) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    spi_sck <= ~spi_sck;
                    if (!spi_sck) begin
                        rx_sh <= {rx_sh[BYTE_W-2:0], spi_miso};
                    end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            active  <= 1'b0;
                            done    <= 1'b1;
                            rx_byte <= rx_sh;
                        end else begin
                            tx_sh <= {tx_sh[BYTE_W-2:0], 1'b0};
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Round-robin sharing of one SPI flash port between the USB bridge (0) and boot reader (1).
module spi_flash_arbiter
    import spi_arb_pkg::*;
#(
    parameter int CLK_DIV        = 2,
    parameter int CS_IDLE_CYCLES = 4
) (
    input  logic                           clk_48mhz,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req,
    output logic [NUM_REQ-1:0]             gnt,
    input  logic [NUM_REQ-1:0]             tx_valid,
    input  logic [NUM_REQ-1:0][BYTE_W-1:0] tx_data,
    output logic [NUM_REQ-1:0]             tx_ready,
    output logic [NUM_REQ-1:0]             rx_valid,
    output logic [BYTE_W-1:0]              rx_data,
    output logic                           busy,
    output logic                           spi_cs,
    output logic                           spi_sck,
    output logic                           spi_mosi,
    input  logic                           spi_miso
);

    localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
    localparam logic [7:0] IDLE_LAST = 8'(CS_IDLE_CYCLES - 1);

    logic [1:0] rst_sync;
    logic       rst_n;
    state_t     state;
    logic       rr_last;
    logic [7:0] cnt;
    logic       win;
    logic       hs;
    logic       req_held;
    logic       done;

    // Assertion reaches every flop at once; release is aligned to the clock.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    // rr_last doubles as the index of the current owner once granted.
    assign win      = pick_winner(req, rr_last);
    assign hs       = (state == WAIT_BYTE) && |(tx_valid & tx_ready);
    assign req_held = |(req & gnt);
    assign rx_valid = gnt & {NUM_REQ{done}};
    assign busy     = (state != IDLE);

    spi_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk      (clk_48mhz),
        .rst_n    (rst_n),
        .start    (hs),
        .tx_byte  (tx_data[rr_last]),
        .done     (done),
        .rx_byte  (rx_data),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso)
    );

    always_ff @(posedge clk_48mhz or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            tx_ready <= '0;
            spi_cs   <= 1'b1;
            rr_last  <= 1'b1;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt      <= '0;
                        gnt[win] <= 1'b1;
                        rr_last  <= win;
                        spi_cs   <= 1'b0;
                        cnt      <= '0;
                        state    <= CS_SETUP;
                    end
                end
                CS_SETUP: begin
                    if (cnt == DIV_LAST) begin
                        cnt      <= '0;
                        tx_ready <= gnt & req;
                        state    <= WAIT_BYTE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WAIT_BYTE: begin
                    if (hs) begin
                        tx_ready <= '0;
                        state    <= SHIFT;
                    end else if (!req_held) begin
                        tx_ready <= '0;
                        cnt      <= '0;
                        state    <= CS_HOLD;
                    end
                end
                SHIFT: begin
                    // A requester that let go mid-byte is not offered another slot.
                    if (done) begin
                        tx_ready <= gnt & req;
                        state    <= WAIT_BYTE;
                    end
                end
                CS_HOLD: begin
                    if (cnt == DIV_LAST) begin
                        cnt    <= '0;
                        spi_cs <= 1'b1;
                        gnt    <= '0;
                        state  <= CS_IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                CS_IDLE: begin
                    if (cnt == IDLE_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench: instance a runs CLK_DIV=2, instance b runs CLK_DIV=1, both with a byte-returning flash model.
module tb_spi_flash_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic [1:0]      a_req, a_gnt, a_tx_valid, a_tx_ready, a_rx_valid;
    logic [1:0][7:0] a_tx_data;
    logic [7:0]      a_rx_data;
    logic            a_busy, a_cs, a_sck, a_mosi, a_miso;
    logic [1:0]      b_req, b_gnt, b_tx_valid, b_tx_ready, b_rx_valid;
    logic [1:0][7:0] b_tx_data;
    logic [7:0]      b_rx_data;
    logic            b_busy, b_cs, b_sck, b_mosi, b_miso;

    spi_flash_arbiter #(.CLK_DIV(2), .CS_IDLE_CYCLES(4)) dut_a (
        .clk_48mhz(clk), .reset_n(reset_n), .req(a_req), .gnt(a_gnt),
        .tx_valid(a_tx_valid), .tx_data(a_tx_data), .tx_ready(a_tx_ready),
        .rx_valid(a_rx_valid), .rx_data(a_rx_data), .busy(a_busy),
        .spi_cs(a_cs), .spi_sck(a_sck), .spi_mosi(a_mosi), .spi_miso(a_miso)
    );

    spi_flash_arbiter #(.CLK_DIV(1), .CS_IDLE_CYCLES(4)) dut_b (
        .clk_48mhz(clk), .reset_n(reset_n), .req(b_req), .gnt(b_gnt),
        .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_ready(b_tx_ready),
        .rx_valid(b_rx_valid), .rx_data(b_rx_data), .busy(b_busy),
        .spi_cs(b_cs), .spi_sck(b_sck), .spi_mosi(b_mosi), .spi_miso(b_miso)
    );

    // Flash model: presents bit 7 while cs is low, advances on each sck falling edge.
    logic [7:0] a_miso_byte, b_miso_byte;
    logic [2:0] a_mcnt = 3'd0, b_mcnt = 3'd0;
    always @(negedge a_sck or posedge a_cs) if (a_cs) a_mcnt <= 3'd0; else a_mcnt <= a_mcnt + 3'd1;
    always @(negedge b_sck or posedge b_cs) if (b_cs) b_mcnt <= 3'd0; else b_mcnt <= b_mcnt + 3'd1;
    assign a_miso = a_miso_byte[~a_mcnt];
    assign b_miso = b_miso_byte[~b_mcnt];

    int a_edges = 0, b_edges = 0, a_cs_rises = 0, a_rx_cnt = 0, inv_viol = 0;
    logic [7:0] a_mosi_cap = 8'd0, b_mosi_cap = 8'd0;
    always @(posedge a_sck or negedge a_sck) a_edges <= a_edges + 1;
    always @(posedge b_sck or negedge b_sck) b_edges <= b_edges + 1;
    always @(posedge a_sck) a_mosi_cap <= {a_mosi_cap[6:0], a_mosi};
    always @(posedge b_sck) b_mosi_cap <= {b_mosi_cap[6:0], b_mosi};
    always @(posedge a_cs) a_cs_rises <= a_cs_rises + 1;
    always @(negedge clk) if (|a_rx_valid) a_rx_cnt <= a_rx_cnt + 1;
    always @(negedge clk) begin
        if ((a_gnt == 2'b11) || (b_gnt == 2'b11) || (a_cs && a_sck) || (b_cs && b_sck) ||
            |(a_rx_valid & ~a_gnt) || |(a_tx_ready & ~a_gnt) ||
            |(b_rx_valid & ~b_gnt) || |(b_tx_ready & ~b_gnt))
            inv_viol <= inv_viol + 1;
    end

    int n_checks = 0, n_fail = 0;
    int a_hs_edges;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic a_send(input int r, input logic [7:0] d, output int lat);
        int n = 0;
        lat = -1;
        while (a_tx_ready[r] !== 1'b1 && n < 50) begin tick(); n++; end
        if (a_tx_ready[r] !== 1'b1) return;
        a_tx_valid[r] = 1'b1; a_tx_data[r] = d; a_hs_edges = a_edges;
        lat = 0;
        do begin tick(); a_tx_valid = '0; lat++; end while (a_rx_valid[r] !== 1'b1 && lat < 100);
    endtask

    task automatic a_wait_idle();
        int n = 0;
        while (a_busy !== 1'b0 && n < 40) begin tick(); n++; end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        n_checks++; if (a_cs !== 1'b1) begin n_fail++; $display("FAIL reset_cs: got %b want 1", a_cs); end
        n_checks++; if (a_sck !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b want 0", a_sck); end
        n_checks++; if (a_mosi !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", a_mosi); end
        n_checks++; if (a_gnt !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b want 00", a_gnt); end
        n_checks++; if (a_tx_ready !== 2'b00) begin n_fail++; $display("FAIL reset_tx_ready: got %b want 00", a_tx_ready); end
        n_checks++; if (a_rx_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rx_valid: got %b want 00", a_rx_valid); end
        n_checks++; if (a_rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", a_rx_data); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        reset_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_single_read();
        int lat, n;
        a_miso_byte = 8'hA5;
        a_req = 2'b01; tick();
        n_checks++; if (a_gnt !== 2'b01) begin n_fail++; $display("FAIL single_gnt: got %b want 01", a_gnt); end
        n_checks++; if (a_cs !== 1'b0) begin n_fail++; $display("FAIL single_cs_low: got %b want 0", a_cs); end
        n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", a_busy); end
        tick();
        n_checks++; if (a_tx_ready !== 2'b00) begin n_fail++; $display("FAIL single_setup_ready: got %b want 00", a_tx_ready); end
        tick();
        n_checks++; if (a_tx_ready !== 2'b01) begin n_fail++; $display("FAIL single_tx_ready: got %b want 01", a_tx_ready); end
        a_send(0, 8'h03, lat);
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL single_latency: got %0d want 33", lat); end
        n_checks++; if (a_rx_data !== 8'hA5) begin n_fail++; $display("FAIL single_rx_data: got %h want a5", a_rx_data); end
        n_checks++; if (a_edges - a_hs_edges != 16) begin n_fail++; $display("FAIL single_sck_edges: got %0d want 16", a_edges - a_hs_edges); end
        n_checks++; if (a_mosi_cap !== 8'h03) begin n_fail++; $display("FAIL single_mosi: got %h want 03", a_mosi_cap); end
        tick();
        n_checks++; if (a_rx_valid !== 2'b00) begin n_fail++; $display("FAIL single_rx_pulse: got %b want 00", a_rx_valid); end
        n_checks++; if (a_tx_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready_again: got %b want 01", a_tx_ready); end
        a_req = 2'b00;
        n = 0; do begin tick(); n++; end while (a_cs !== 1'b1 && n < 20);
        n_checks++; if (n != 3) begin n_fail++; $display("FAIL single_cs_rise: got %0d cycles want 3", n); end
        n_checks++; if (a_gnt !== 2'b00) begin n_fail++; $display("FAIL single_gnt_drop: got %b want 00", a_gnt); end
        a_wait_idle();
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", a_busy); end
    endtask

    task automatic test_contention();
        int lat, n, hi;
        reset_n = 1'b0; tick(); reset_n = 1'b1; repeat (3) tick();
        a_req = 2'b11; tick();
        n_checks++; if (a_gnt !== 2'b01) begin n_fail++; $display("FAIL cont_first: got %b want 01", a_gnt); end
        a_send(0, 8'h11, lat);
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL cont_lat0: got %0d want 33", lat); end
        tick();
        a_req[0] = 1'b0;
        n = 0; hi = 0;
        do begin tick(); n++; if (a_cs === 1'b1) hi++; end while (a_gnt !== 2'b10 && n < 30);
        n_checks++; if (a_gnt !== 2'b10) begin n_fail++; $display("FAIL cont_second: got %b want 10", a_gnt); end
        n_checks++; if (hi < 4) begin n_fail++; $display("FAIL cont_cs_high: got %0d cycles want >=4", hi); end
        a_send(1, 8'h22, lat);
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL cont_lat1: got %0d want 33", lat); end
        tick();
        a_req = 2'b01; tick();
        a_req = 2'b11;
        n = 0; while (a_gnt === 2'b00 || a_gnt === 2'b10) begin if (n >= 30) break; tick(); n++; end
        n_checks++; if (a_gnt !== 2'b01) begin n_fail++; $display("FAIL cont_alternate: got %b want 01", a_gnt); end
        a_req = 2'b00;
        a_wait_idle(); repeat (5) tick();
        n_checks++; if (a_gnt !== 2'b00) begin n_fail++; $display("FAIL cont_dropped_req: got %b want 00", a_gnt); end
        n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL cont_idle: got %b want 0", a_busy); end
    endtask

    task automatic test_multi_byte();
        logic [7:0] bytes [4] = '{8'h9F, 8'h00, 8'h00, 8'h00};
        int lat, n, rises, rxc;
        a_miso_byte = 8'h3C;
        a_req = 2'b10; tick();
        n_checks++; if (a_gnt !== 2'b10) begin n_fail++; $display("FAIL multi_gnt: got %b want 10", a_gnt); end
        rises = a_cs_rises; rxc = a_rx_cnt;
        for (int i = 0; i < 4; i++) begin
            a_send(1, bytes[i], lat);
            n_checks++; if (lat != 33) begin n_fail++; $display("FAIL multi_lat%0d: got %0d want 33", i, lat); end
            n_checks++; if (a_rx_data !== 8'h3C) begin n_fail++; $display("FAIL multi_rx%0d: got %h want 3c", i, a_rx_data); end
        end
        tick();
        n_checks++; if (a_cs_rises != rises) begin n_fail++; $display("FAIL multi_cs_held: got %0d rises want 0", a_cs_rises - rises); end
        n_checks++; if (a_rx_cnt - rxc != 4) begin n_fail++; $display("FAIL multi_rx_count: got %0d want 4", a_rx_cnt - rxc); end
        a_req = 2'b00;
        n = 0; do begin tick(); n++; end while (a_cs !== 1'b1 && n < 20);
        n_checks++; if (n != 3) begin n_fail++; $display("FAIL multi_cs_rise: got %0d cycles want 3", n); end
        a_wait_idle();
    endtask

    task automatic test_drop_mid_shift();
        int lat, n, rdy;
        a_miso_byte = 8'h5A;
        a_req = 2'b01; tick();
        n = 0; while (a_tx_ready[0] !== 1'b1 && n < 50) begin tick(); n++; end
        a_tx_valid[0] = 1'b1; a_tx_data[0] = 8'h44;
        tick(); a_tx_valid = '0; tick(); tick();
        a_req = 2'b00;
        lat = 3; while (a_rx_valid[0] !== 1'b1 && lat < 100) begin tick(); lat++; end
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL drop_lat: got %0d want 33", lat); end
        n_checks++; if (a_rx_data !== 8'h5A) begin n_fail++; $display("FAIL drop_rx: got %h want 5a", a_rx_data); end
        n = 0; rdy = 0;
        do begin tick(); n++; if (a_tx_ready !== 2'b00) rdy++; end while (a_cs !== 1'b1 && n < 20);
        n_checks++; if (rdy != 0) begin n_fail++; $display("FAIL drop_extra_ready: got %0d cycles want 0", rdy); end
        n_checks++; if (n != 4) begin n_fail++; $display("FAIL drop_cs_rise: got %0d cycles want 4", n); end
        a_wait_idle();
    endtask

    task automatic test_reset_mid_shift();
        int lat, n, rxc;
        a_miso_byte = 8'hA5;
        a_req = 2'b01; tick();
        n = 0; while (a_tx_ready[0] !== 1'b1 && n < 50) begin tick(); n++; end
        a_tx_valid[0] = 1'b1; a_tx_data[0] = 8'hF0;
        tick(); a_tx_valid = '0; tick(); tick();
        n_checks++; if (a_sck !== 1'b1) begin n_fail++; $display("FAIL rst_pre_sck: got %b want 1", a_sck); end
        rxc = a_rx_cnt;
        reset_n = 1'b0; a_req = 2'b00; #2;
        n_checks++; if (a_cs !== 1'b1) begin n_fail++; $display("FAIL rst_async_cs: got %b want 1", a_cs); end
        n_checks++; if (a_sck !== 1'b0) begin n_fail++; $display("FAIL rst_async_sck: got %b want 0", a_sck); end
        n_checks++; if (a_gnt !== 2'b00) begin n_fail++; $display("FAIL rst_async_gnt: got %b want 00", a_gnt); end
        tick(); reset_n = 1'b1; repeat (3) tick();
        n_checks++; if (a_rx_cnt != rxc) begin n_fail++; $display("FAIL rst_partial_rx: got %0d pulses want 0", a_rx_cnt - rxc); end
        a_req = 2'b01; tick();
        n_checks++; if (a_gnt !== 2'b01) begin n_fail++; $display("FAIL rst_regrant: got %b want 01", a_gnt); end
        a_send(0, 8'h9F, lat);
        n_checks++; if (lat != 33) begin n_fail++; $display("FAIL rst_lat: got %0d want 33", lat); end
        n_checks++; if (a_rx_data !== 8'hA5) begin n_fail++; $display("FAIL rst_rx: got %h want a5", a_rx_data); end
        tick(); a_req = 2'b00;
        a_wait_idle();
    endtask

    task automatic test_clk_div1();
        int lat, n, e;
        b_miso_byte = 8'hC3;
        b_req = 2'b01; tick();
        n_checks++; if (b_gnt !== 2'b01) begin n_fail++; $display("FAIL div1_gnt: got %b want 01", b_gnt); end
        tick();
        n_checks++; if (b_tx_ready !== 2'b01) begin n_fail++; $display("FAIL div1_ready: got %b want 01", b_tx_ready); end
        b_tx_valid[0] = 1'b1; b_tx_data[0] = 8'h81; e = b_edges;
        tick(); b_tx_valid = '0;
        n_checks++; if (b_sck !== 1'b0) begin n_fail++; $display("FAIL div1_sck_c1: got %b want 0", b_sck); end
        tick();
        n_checks++; if (b_sck !== 1'b1) begin n_fail++; $display("FAIL div1_sck_c2: got %b want 1", b_sck); end
        tick();
        n_checks++; if (b_sck !== 1'b0) begin n_fail++; $display("FAIL div1_sck_c3: got %b want 0", b_sck); end
        lat = 3; while (b_rx_valid[0] !== 1'b1 && lat < 100) begin tick(); lat++; end
        n_checks++; if (lat != 17) begin n_fail++; $display("FAIL div1_lat: got %0d want 17", lat); end
        n_checks++; if (b_rx_data !== 8'hC3) begin n_fail++; $display("FAIL div1_rx: got %h want c3", b_rx_data); end
        n_checks++; if (b_edges - e != 16) begin n_fail++; $display("FAIL div1_edges: got %0d want 16", b_edges - e); end
        n_checks++; if (b_mosi_cap !== 8'h81) begin n_fail++; $display("FAIL div1_mosi: got %h want 81", b_mosi_cap); end
        tick(); b_req = 2'b00;
        n = 0; while (b_busy !== 1'b0 && n < 40) begin tick(); n++; end
        n_checks++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL div1_idle: got %b want 0", b_busy); end
    endtask

    task automatic test_invariants();
        n_checks++; if (inv_viol != 0) begin n_fail++; $display("FAIL invariants: got %0d violating cycles want 0", inv_viol); end
    endtask

    initial begin
        reset_n = 1'b0;
        a_req = '0; a_tx_valid = '0; a_tx_data = '0; a_miso_byte = 8'h00;
        b_req = '0; b_tx_valid = '0; b_tx_data = '0; b_miso_byte = 8'h00;
        test_reset();
        test_single_read();
        test_contention();
        test_multi_byte();
        test_drop_mid_shift();
        test_reset_mid_shift();
        test_clk_div1();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
